// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one SerialTx between several requesters,
// with per-owner lock for back-to-back multi-word frames and a start timeout.
module serial_tx_arbiter #(
    parameter int Requesters   = 4,
    parameter int Width        = 8,
    parameter int StartTimeout = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [Requesters-1:0]            req,
    input  logic [Requesters-1:0]            lock,
    input  logic [Requesters*Width-1:0]      req_data,
    output logic [Requesters-1:0]            ack,
    output logic                             tx_ce,
    output logic [Width-1:0]                 tx_data,
    input  logic                             tx_busy,
    output logic [$clog2(Requesters)-1:0]    grant,
    output logic                             active,
    output logic                             err
);
    localparam int GW = $clog2(Requesters);
    localparam int TW = $clog2(StartTimeout) + 1;
    localparam logic [GW:0] RN = (GW+1)'(Requesters);
    localparam logic [Requesters-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, START, SEND} state_t;

    state_t         state;
    logic [GW-1:0]  ptr;
    logic [GW-1:0]  win;
    logic [GW-1:0]  nxt;
    logic [GW:0]    s;
    logic           found;
    logic [TW-1:0]  timer;

    // Scan downwards so the candidate closest to ptr is the last to overwrite win.
    always_comb begin
        win   = '0;
        found = 1'b0;
        s     = '0;
        for (int k = Requesters - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (GW+1)'(k);
            s = (s >= RN) ? s - RN : s;
            if (req[GW'(s)]) begin
                win   = GW'(s);
                found = 1'b1;
            end
        end
        nxt = (grant == GW'(Requesters - 1)) ? '0 : grant + GW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack     <= '0;
            tx_ce   <= 1'b0;
            tx_data <= '0;
            grant   <= '0;
            active  <= 1'b0;
            err     <= 1'b0;
            timer   <= '0;
            ptr     <= '0;
        end else begin
            ack   <= '0;
            tx_ce <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_busy && found) begin
                        tx_data <= req_data[win*Width +: Width];
                        tx_ce   <= 1'b1;
                        ack     <= ONE << win;
                        grant   <= win;
                        active  <= 1'b1;
                        timer   <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tx_busy) begin
                        state <= SEND;
                    end else if (timer == TW'(StartTimeout - 1)) begin
                        err    <= 1'b1;
                        active <= 1'b0;
                        ptr    <= nxt;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        // A locked owner with more words keeps the line with no idle cycle.
                        if (lock[grant] && req[grant]) begin
                            tx_data <= req_data[grant*Width +: Width];
                            tx_ce   <= 1'b1;
                            ack     <= ONE << grant;
                            timer   <= '0;
                            state   <= START;
                        end else begin
                            active <= 1'b0;
                            if (!lock[grant])
                                ptr <= nxt;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: randomized and directed checks of serial_tx_arbiter against
// a word-queue round-robin model and a simple SerialTx busy model.
module tb_serial_tx_arbiter;
    localparam int F = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_ce;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant;
    logic        active;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    int          mode = 0;
    int          cnt = 0;
    int          ptr_m = 0;
    logic [7:0]  frame_log[$];
    logic [7:0]  wq[4][$];

    serial_tx_arbiter #(.Requesters(4), .Width(8), .StartTimeout(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_data(req_data),
        .ack(ack), .tx_ce(tx_ce), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant(grant), .active(active), .err(err)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: busy for F cycles after each load; mode 1 never busy, mode 2 always busy.
    always @(posedge clk) begin
        if (mode == 2) begin
            tx_busy <= 1'b1;
            cnt     <= 0;
        end else if (mode == 1) begin
            tx_busy <= 1'b0;
            cnt     <= 0;
        end else if (tx_ce === 1'b1) begin
            tx_busy <= 1'b1;
            cnt     <= F;
            frame_log.push_back(tx_data);
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else begin
            cnt     <= 0;
            tx_busy <= 1'b0;
        end
    end

    function automatic int rr(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = wq[i].size() > 0;
            req_data[i*8 +: 8] = (wq[i].size() > 0) ? wq[i][0] : 8'h00;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        req_data = '0;
        mode  = 0;
        for (int i = 0; i < 4; i++) wq[i].delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic run(input int first_gap, input string name);
        int         cyc, last, e, n, prev, gap;
        logic       cont;
        logic [7:0] w;
        logic [7:0] exp_q[$];
        logic [3:0] m;
        cyc = 0; last = 0; n = 0; prev = 0; cont = 1'b0;
        frame_log.delete();
        drive();
        while ((req != 0 || active !== 1'b0 || tx_busy) && cyc < 3000) begin
            @(posedge clk);
            #1 cyc++;
            checks++;
            if (tx_ce !== (ack != 0) || !$onehot0(ack) || err !== 1'b0) begin
                errors++;
                $display("FAIL %s strobe: tx_ce=%b ack=%b err=%b", name, tx_ce, ack, err);
            end
            if (tx_ce === 1'b1) begin
                m = req;
                e = cont ? prev : rr(m, ptr_m);
                checks++;
                if (e < 0) begin
                    errors++;
                    $display("FAIL %s spurious load: ack=%b with req=%b", name, ack, m);
                end else begin
                    w = wq[e][0];
                    if (ack !== 4'(1 << e) || grant !== 2'(e) || tx_data !== w) begin
                        errors++;
                        $display("FAIL %s load: ack=%b grant=%0d data=%h, want ack=%b grant=%0d data=%h",
                                 name, ack, grant, tx_data, 4'(1 << e), e, w);
                    end
                    gap = (n == 0) ? first_gap : (cont ? F + 2 : F + 3);
                    checks++;
                    if (cyc - last != gap) begin
                        errors++;
                        $display("FAIL %s gap: got %0d cycles, want %0d", name, cyc - last, gap);
                    end
                    exp_q.push_back(w);
                    w = wq[e].pop_front();
                    cont = lock[e] && wq[e].size() > 0;
                    prev = e;
                    if (!lock[e]) ptr_m = (e + 1) % 4;
                    last = cyc;
                    n++;
                    drive();
                end
            end
        end
        checks++;
        if (cyc >= 3000 || req != 0) begin
            errors++;
            $display("FAIL %s timeout: cycles=%0d req=%b", name, cyc, req);
        end
        checks++;
        if (frame_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s frames: got %0d frames, want %0d", name, frame_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (frame_log[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s frame %0d: got %h, want %h", name, i, frame_log[i], exp_q[i]);
                end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ack !== 0 || tx_ce !== 0 || tx_data !== 0 || grant !== 0 || active !== 0 || err !== 0) begin
            errors++;
            $display("FAIL reset: ack=%b ce=%b data=%h grant=%0d active=%b err=%b, want all 0",
                     ack, tx_ce, tx_data, grant, active, err);
        end
    endtask

    task automatic test_reset_mid_send();
        int         n;
        logic [7:0] w;
        do_reset();
        wq[3].push_back(8'h33);
        drive();
        n = 0;
        while (tx_ce !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        w = wq[3].pop_front();
        drive();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 0 || tx_ce !== 0 || tx_data !== 0 || grant !== 0 || active !== 0 || err !== 0) begin
            errors++;
            $display("FAIL reset_mid_send: ack=%b ce=%b data=%h grant=%0d active=%b err=%b, want all 0",
                     ack, tx_ce, tx_data, grant, active, err);
        end
        n = 0;
        while (tx_busy && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        ptr_m = 0;
        wq[0].push_back(8'h01);
        run(1, "reset_release");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) wq[i].push_back(8'hA0 + 8'(i));
        run(1, "round_robin");
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wq[1].push_back(8'h10 + 8'(i));
            wq[3].push_back(8'h30 + 8'(i));
        end
        run(1, "alternate");
    endtask

    task automatic test_lock();
        do_reset();
        wq[1].push_back(8'h44);
        run(1, "lock_prep");
        lock = 4'b0100;
        wq[2].push_back(8'h55);
        wq[2].push_back(8'hAA);
        wq[2].push_back(8'h0F);
        wq[0].push_back(8'h99);
        run(1, "lock");
        lock = '0;
    endtask

    task automatic test_timeout();
        int         n;
        logic [7:0] w;
        do_reset();
        mode = 1;
        wq[1].push_back(8'h5A);
        drive();
        n = 0;
        while (tx_ce !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n != 1 || ack !== 4'b0010 || grant !== 2'd1 || tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL timeout_load: after %0d cycles ack=%b grant=%0d data=%h, want 1 cycle ack=0010 grant=1 data=5a",
                     n, ack, grant, tx_data);
        end
        w = wq[1].pop_front();
        drive();
        n = 0;
        while (err !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
            checks++;
            if (tx_ce !== 1'b0 || ack !== 0) begin
                errors++;
                $display("FAIL timeout_quiet: tx_ce=%b ack=%b, want 0", tx_ce, ack);
            end
        end
        checks++;
        if (n != 4 || active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err after %0d cycles active=%b, want 4 cycles active=0", n, active);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b one cycle later, want 0", err);
        end
        mode = 0;
        ptr_m = 2;
        wq[0].push_back(8'hC0);
        wq[2].push_back(8'hC2);
        run(1, "after_timeout");
    endtask

    task automatic test_busy_hold();
        do_reset();
        mode = 2;
        repeat (2) @(posedge clk);
        #1 wq[2].push_back(8'h77);
        drive();
        repeat (10) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_ce !== 1'b0 || ack !== 0) begin
                errors++;
                $display("FAIL busy_hold: tx_ce=%b ack=%b while busy, want 0", tx_ce, ack);
            end
        end
        mode = 0;
        run(2, "busy_release");
    endtask

    task automatic test_random();
        int total;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            lock = 4'($urandom);
            total = 0;
            for (int i = 0; i < 4; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) wq[i].push_back(8'($urandom));
                total += n;
            end
            if (total == 0) wq[$urandom_range(0, 3)].push_back(8'($urandom));
            run(1, "random");
            lock = '0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        lock = '0;
        req_data = '0;
        test_reset();
        test_reset_mid_send();
        test_round_robin();
        test_alternate();
        test_lock();
        test_timeout();
        test_busy_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
